mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter that multiplexes instruction fetch and data
// load/store requests onto one SRAM-like bus, one transaction at a time.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        i_stall,
    output logic        d_stall
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t      state;
    state_t      nextState;

    logic        grantData;
    logic        latWr;
    logic [1:0]  latSize;
    logic [31:0] latAddr;
    logic [31:0] latWdata;
    logic [31:0] instRdataQ;
    logic [31:0] dataRdataQ;

    logic        grantEn;
    logic        grantDataNext;
    logic        respDone;
    logic        instOk;
    logic        dataOk;

    always_comb begin
        nextState     = state;
        grantEn       = 1'b0;
        grantDataNext = 1'b0;
        respDone      = 1'b0;
        unique case (state)
            IDLE: begin
                if (data_req) begin
                    grantEn       = 1'b1;
                    grantDataNext = 1'b1;
                    nextState     = ADDR;
                end else if (inst_req) begin
                    grantEn   = 1'b1;
                    nextState = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    nextState = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    respDone  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // A requester that withdrew mid-transaction gets no completion pulse.
    assign instOk = respDone & ~grantData & inst_req;
    assign dataOk = respDone & grantData & data_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grantData  <= 1'b0;
            latWr      <= 1'b0;
            latSize    <= 2'd0;
            latAddr    <= 32'd0;
            latWdata   <= 32'd0;
            instRdataQ <= 32'd0;
            dataRdataQ <= 32'd0;
        end else begin
            state <= nextState;
            if (grantEn) begin
                grantData <= grantDataNext;
                latWr     <= grantDataNext ? data_wr : 1'b0;
                latSize   <= grantDataNext ? data_size : 2'd2;
                latAddr   <= grantDataNext ? data_addr : inst_addr;
                latWdata  <= grantDataNext ? data_wdata : 32'd0;
            end
            if (instOk) begin
                instRdataQ <= bus_rdata;
            end
            if (dataOk) begin
                dataRdataQ <= bus_rdata;
            end
        end
    end

    assign bus_req   = (state == ADDR);
    assign bus_wr    = latWr;
    assign bus_size  = latSize;
    assign bus_addr  = latAddr;
    assign bus_wdata = latWdata;

    assign inst_data_ok = instOk;
    assign data_data_ok = dataOk;
    assign inst_rdata   = instOk ? bus_rdata : instRdataQ;
    assign data_rdata   = dataOk ? bus_rdata : dataRdataQ;

    assign i_stall = inst_req & ~instOk;
    assign d_stall = data_req & ~dataOk;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: fetch, contention, address
// hold, spurious response, withdrawal and mid-transaction reset.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        i_stall;
    logic        d_stall;

    int nChecks = 0;
    int nPass   = 0;

    mem_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .i_stall      (i_stall),
        .d_stall      (d_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nChecks++;
        if (obs === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and checks happen
    // well clear of the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst         = 1'b1;
        inst_req    = 1'b0;
        inst_addr   = 32'd0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = 32'd0;
        data_wdata  = 32'd0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_wr", {31'd0, bus_wr}, 32'd0);
        chk("rst_bus_size", {30'd0, bus_size}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_iok", {31'd0, inst_data_ok}, 32'd0);
        chk("rst_dok", {31'd0, data_data_ok}, 32'd0);
        chk("rst_istall", {31'd0, i_stall}, 32'd0);

        // Single fetch
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        #1;
        chk("f_istall", {31'd0, i_stall}, 32'd1);
        chk("f_idle_req", {31'd0, bus_req}, 32'd0);
        tick();
        bus_addr_ok = 1'b1;
        #1;
        chk("f_bus_req", {31'd0, bus_req}, 32'd1);
        chk("f_bus_addr", bus_addr, 32'hBFC0_0000);
        chk("f_bus_size", {30'd0, bus_size}, 32'd2);
        chk("f_bus_wr", {31'd0, bus_wr}, 32'd0);
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h2408_0001;
        #1;
        chk("f_iok", {31'd0, inst_data_ok}, 32'd1);
        chk("f_irdata", inst_rdata, 32'h2408_0001);
        chk("f_istall_done", {31'd0, i_stall}, 32'd0);
        chk("f_dok", {31'd0, data_data_ok}, 32'd0);
        tick();
        inst_req    = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'hFFFF_FFFF;
        #1;
        chk("f_iok_pulse", {31'd0, inst_data_ok}, 32'd0);
        chk("f_irdata_hold", inst_rdata, 32'h2408_0001);

        // Load with address hold and a spurious response in ADDR
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd1;
        data_addr = 32'h0000_0100;
        tick();
        for (int i = 0; i < 5; i++) begin
            data_addr   = 32'h0000_0200 + i;
            bus_data_ok = (i == 0);
            #1;
            chk("h_bus_req", {31'd0, bus_req}, 32'd1);
            chk("h_bus_addr", bus_addr, 32'h0000_0100);
            chk("h_bus_size", {30'd0, bus_size}, 32'd1);
            chk("h_dok", {31'd0, data_data_ok}, 32'd0);
            tick();
        end
        bus_data_ok = 1'b0;
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h5555_AAAA;
        #1;
        chk("h_dok_done", {31'd0, data_data_ok}, 32'd1);
        chk("h_drdata", data_rdata, 32'h5555_AAAA);
        tick();
        data_req    = 1'b0;
        bus_data_ok = 1'b0;

        // Contention: store wins, fetch follows
        inst_req   = 1'b1;
        inst_addr  = 32'hBFC0_0004;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = 32'h8000_0010;
        data_wdata = 32'hDEAD_BEEF;
        #1;
        chk("c_dstall", {31'd0, d_stall}, 32'd1);
        tick();
        bus_addr_ok = 1'b1;
        #1;
        chk("c_s_addr", bus_addr, 32'h8000_0010);
        chk("c_s_wr", {31'd0, bus_wr}, 32'd1);
        chk("c_s_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("c_s_size", {30'd0, bus_size}, 32'd2);
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h0;
        #1;
        chk("c_s_dok", {31'd0, data_data_ok}, 32'd1);
        chk("c_s_iok", {31'd0, inst_data_ok}, 32'd0);
        chk("c_s_istall", {31'd0, i_stall}, 32'd1);
        tick();
        data_req    = 1'b0;
        bus_data_ok = 1'b0;
        #1;
        chk("c_idle_istall", {31'd0, i_stall}, 32'd1);
        chk("c_idle_req", {31'd0, bus_req}, 32'd0);
        tick();
        bus_addr_ok = 1'b1;
        #1;
        chk("c_f_req", {31'd0, bus_req}, 32'd1);
        chk("c_f_addr", bus_addr, 32'hBFC0_0004);
        chk("c_f_wr", {31'd0, bus_wr}, 32'd0);
        chk("c_f_istall", {31'd0, i_stall}, 32'd1);
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h1111_2222;
        #1;
        chk("c_f_iok", {31'd0, inst_data_ok}, 32'd1);
        chk("c_f_irdata", inst_rdata, 32'h1111_2222);
        chk("c_f_dok", {31'd0, data_data_ok}, 32'd0);
        tick();
        bus_data_ok = 1'b0;
        inst_req    = 1'b0;

        // Withdrawal during DATA
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0008;
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        inst_req    = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h3333_3333;
        #1;
        chk("w_iok", {31'd0, inst_data_ok}, 32'd0);
        chk("w_irdata_hold", inst_rdata, 32'h1111_2222);
        tick();
        bus_data_ok = 1'b0;
        #1;
        chk("w_idle_req", {31'd0, bus_req}, 32'd0);
        tick();
        chk("w_idle_req2", {31'd0, bus_req}, 32'd0);

        // Reset while in ADDR
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = 32'h0000_0040;
        tick();
        #1;
        chk("r_addr_req", {31'd0, bus_req}, 32'd1);
        rst      = 1'b1;
        data_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("r_bus_req", {31'd0, bus_req}, 32'd0);
        chk("r_bus_addr", bus_addr, 32'd0);
        chk("r_drdata", data_rdata, 32'd0);
        chk("r_irdata", inst_rdata, 32'd0);
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h7777_7777;
        #1;
        chk("r_dok", {31'd0, data_data_ok}, 32'd0);
        chk("r_iok", {31'd0, inst_data_ok}, 32'd0);
        tick();
        bus_data_ok = 1'b0;
        #1;
        chk("r_idle_req", {31'd0, bus_req}, 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
